// File: rtl/display_timing_gen.sv
// Display timing generator: free-running horizontal/vertical scan counters with a
// registered coordinate, sync, video_on and tick decode. Define DTG_PIX_EN_EN to add pix_en.
module display_timing_gen #(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 136,
    parameter int unsigned H_BP     = 160,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 29,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
`ifdef DTG_PIX_EN_EN
    input  logic        pix_en,
`endif
    output logic [11:0] pixel_column,
    output logic [11:0] pixel_row,
    output logic        video_on,
    output logic        horiz_sync,
    output logic        vert_sync,
    output logic        line_tick,
    output logic        frame_tick
);

    localparam int unsigned CNT_W = 12;
    localparam int unsigned SUM_W = 13;

    localparam logic [SUM_W-1:0] H_VIS      = SUM_W'(H_ACTIVE);
    localparam logic [SUM_W-1:0] H_SYNC_BEG = SUM_W'(H_ACTIVE) + SUM_W'(H_FP);
    localparam logic [SUM_W-1:0] H_SYNC_END = H_SYNC_BEG + SUM_W'(H_SYNC);
    localparam logic [SUM_W-1:0] H_TOTAL    = H_SYNC_END + SUM_W'(H_BP);

    localparam logic [SUM_W-1:0] V_VIS      = SUM_W'(V_ACTIVE);
    localparam logic [SUM_W-1:0] V_SYNC_BEG = SUM_W'(V_ACTIVE) + SUM_W'(V_FP);
    localparam logic [SUM_W-1:0] V_SYNC_END = V_SYNC_BEG + SUM_W'(V_SYNC);
    localparam logic [SUM_W-1:0] V_TOTAL    = V_SYNC_END + SUM_W'(V_BP);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic [SUM_W-1:0] h_ext;
    logic [SUM_W-1:0] v_ext;
    logic             adv;
    logic             h_last;
    logic             v_last;
    logic             vid_d;
    logic             hs_d;
    logic             vs_d;
    logic             line_d;
    logic             frame_d;

`ifdef DTG_PIX_EN_EN
    assign adv = pix_en;
`else
    assign adv = 1'b1;
`endif

    // Next counter values and output decode of the current scan position.
    always_comb begin
        h_ext   = SUM_W'(h_cnt);
        v_ext   = SUM_W'(v_cnt);
        h_last  = (h_ext == H_TOTAL - SUM_W'(1));
        v_last  = (v_ext == V_TOTAL - SUM_W'(1));
        h_nxt   = h_cnt + CNT_W'(1);
        v_nxt   = v_cnt;
        if (h_last) begin
            h_nxt = '0;
            v_nxt = v_last ? '0 : v_cnt + CNT_W'(1);
        end
        vid_d   = (h_ext < H_VIS) && (v_ext < V_VIS);
        hs_d    = ((h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        vs_d    = ((v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        line_d  = (h_cnt == '0);
        frame_d = (h_cnt == '0) && (v_cnt == '0);
    end

    // Scan counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (adv) begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    // Registered outputs; ticks fall on the next clk edge whether or not it advances.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_column <= '0;
            pixel_row    <= '0;
            video_on     <= 1'b0;
            horiz_sync   <= ~SYNC_POL;
            vert_sync    <= ~SYNC_POL;
            line_tick    <= 1'b0;
            frame_tick   <= 1'b0;
        end else begin
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
            if (adv) begin
                pixel_column <= h_cnt;
                pixel_row    <= v_cnt;
                video_on     <= vid_d;
                horiz_sync   <= hs_d;
                vert_sync    <= vs_d;
                line_tick    <= line_d;
                frame_tick   <= frame_d;
            end
        end
    end

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen: a full-size instance and a small-timing instance
// (positive sync) checked every cycle against an index-based scan model.
module tb_display_timing_gen;

    localparam int BHA = 1024, BHFP = 24, BHS = 136, BHBP = 160;
    localparam int BVA = 768,  BVFP = 3,  BVS = 6,   BVBP = 29;
    localparam int BHT = BHA + BHFP + BHS + BHBP;
    localparam int SHA = 16, SHFP = 4, SHS = 6, SHBP = 5;
    localparam int SVA = 10, SVFP = 2, SVS = 3, SVBP = 4;
    localparam int SHT = SHA + SHFP + SHS + SHBP;
    localparam int SVT = SVA + SVFP + SVS + SVBP;
    localparam int SFRAME = SHT * SVT;
`ifdef DTG_PIX_EN_EN
    localparam bit HAS_EN = 1'b1;
`else
    localparam bit HAS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [11:0] col;
        logic [11:0] row;
        logic        vid;
        logic        hs;
        logic        vs;
        logic        lt;
        logic        ft;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    logic pix_en;
    logic [11:0] b_col, b_row, s_col, s_row;
    logic b_vid, b_hs, b_vs, b_lt, b_ft, s_vid, s_hs, s_vs, s_lt, s_ft;
    obs_t got_b, got_s;

    int unsigned nb, ns;
    bit          last_adv;
    int          checks, errors;

    always #5 clk = ~clk;

    assign got_b = {b_col, b_row, b_vid, b_hs, b_vs, b_lt, b_ft};
    assign got_s = {s_col, s_row, s_vid, s_hs, s_vs, s_lt, s_ft};

    display_timing_gen dut_big (
        .clk(clk), .reset(reset),
`ifdef DTG_PIX_EN_EN
        .pix_en(pix_en),
`endif
        .pixel_column(b_col), .pixel_row(b_row), .video_on(b_vid),
        .horiz_sync(b_hs), .vert_sync(b_vs), .line_tick(b_lt), .frame_tick(b_ft)
    );

    display_timing_gen #(
        .H_ACTIVE(SHA), .H_FP(SHFP), .H_SYNC(SHS), .H_BP(SHBP),
        .V_ACTIVE(SVA), .V_FP(SVFP), .V_SYNC(SVS), .V_BP(SVBP), .SYNC_POL(1'b1)
    ) dut_small (
        .clk(clk), .reset(reset),
`ifdef DTG_PIX_EN_EN
        .pix_en(pix_en),
`endif
        .pixel_column(s_col), .pixel_row(s_row), .video_on(s_vid),
        .horiz_sync(s_hs), .vert_sync(s_vs), .line_tick(s_lt), .frame_tick(s_ft)
    );

    // n = advances since reset; the n-th advance shows scan index n-1 in raster order.
    function automatic obs_t model(input int ha, input int hfp, input int hsw, input int hbp,
                                   input int va, input int vfp, input int vsw, input int vbp,
                                   input logic pol, input int unsigned n, input bit adv);
        obs_t o;
        int ht, vt, idx, h, v;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        o = '0;
        o.hs = ~pol;
        o.vs = ~pol;
        if (n == 0) return o;
        idx   = int'(n) - 1;
        h     = idx % ht;
        v     = (idx / ht) % vt;
        o.col = 12'(h);
        o.row = 12'(v);
        o.vid = (h < ha) && (v < va);
        o.hs  = (h >= ha + hfp && h < ha + hfp + hsw) ? pol : ~pol;
        o.vs  = (v >= va + vfp && v < va + vfp + vsw) ? pol : ~pol;
        o.lt  = adv && (h == 0);
        o.ft  = adv && (h == 0) && (v == 0);
        return o;
    endfunction

    function automatic obs_t exp_b();
        return model(BHA, BHFP, BHS, BHBP, BVA, BVFP, BVS, BVBP, 1'b0, nb, last_adv);
    endfunction

    function automatic obs_t exp_s();
        return model(SHA, SHFP, SHS, SHBP, SVA, SVFP, SVS, SVBP, 1'b1, ns, last_adv);
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("col=%0d row=%0d vid=%0b hs=%0b vs=%0b lt=%0b ft=%0b",
                         o.col, o.row, o.vid, o.hs, o.vs, o.lt, o.ft);
    endfunction

    // One clk edge; outputs are settled 1 time unit after it.
    task automatic tick(input bit en);
        pix_en = en;
        @(posedge clk);
        last_adv = reset && (pix_en || !HAS_EN);
        if (last_adv) begin
            nb++;
            ns++;
        end
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset    = 1'b0;
        nb       = 0;
        ns       = 0;
        last_adv = 1'b0;
        repeat (cycles) tick(1'b1);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        obs_t rst_b, rst_s, first_b;
        rst_b   = {12'd0, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        rst_s   = {12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        first_b = {12'd0, 12'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        reset = 1'b0;
        nb = 0; ns = 0; last_adv = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1);
            checks++;
            if (got_b !== rst_b) begin
                errors++;
                $display("FAIL reset_hold_big cyc=%0d: got %s expected %s", i, fmt(got_b), fmt(rst_b));
            end
            checks++;
            if (got_s !== rst_s) begin
                errors++;
                $display("FAIL reset_hold_small cyc=%0d: got %s expected %s", i, fmt(got_s), fmt(rst_s));
            end
        end
        reset = 1'b1;
        tick(1'b1);
        checks++;
        if (got_b !== first_b) begin
            errors++;
            $display("FAIL reset_first_edge: got %s expected %s", fmt(got_b), fmt(first_b));
        end
    endtask

    task automatic test_horizontal();
        obs_t e;
        int hs_fall_col, hs_low_len, vid_fall_col, lt_period, last_lt, run;
        logic prev_hs, prev_vid;
        hs_fall_col = -1; hs_low_len = -1; vid_fall_col = -1; lt_period = -1; last_lt = -1; run = 0;
        do_reset(2);
        prev_hs = got_b.hs;
        prev_vid = got_b.vid;
        for (int cyc = 0; cyc < 3 * BHT + 5; cyc++) begin
            tick(1'b1);
            e = exp_b();
            checks++;
            if (got_b !== e) begin
                errors++;
                $display("FAIL horiz_scan @%0t: got %s expected %s", $time, fmt(got_b), fmt(e));
            end
            if (prev_hs && !got_b.hs && hs_fall_col < 0) hs_fall_col = int'(got_b.col);
            if (!got_b.hs) run++;
            else if (run > 0) begin
                if (hs_low_len < 0) hs_low_len = run;
                run = 0;
            end
            if (prev_vid && !got_b.vid && vid_fall_col < 0) vid_fall_col = int'(got_b.col);
            if (got_b.lt) begin
                if (last_lt >= 0 && lt_period < 0) lt_period = cyc - last_lt;
                last_lt = cyc;
            end
            prev_hs = got_b.hs;
            prev_vid = got_b.vid;
        end
        checks++;
        if (hs_fall_col != BHA + BHFP) begin
            errors++;
            $display("FAIL hsync_start_col: got %0d expected %0d", hs_fall_col, BHA + BHFP);
        end
        checks++;
        if (hs_low_len != BHS) begin
            errors++;
            $display("FAIL hsync_width: got %0d expected %0d", hs_low_len, BHS);
        end
        checks++;
        if (vid_fall_col != BHA) begin
            errors++;
            $display("FAIL video_off_col: got %0d expected %0d", vid_fall_col, BHA);
        end
        checks++;
        if (lt_period != BHT) begin
            errors++;
            $display("FAIL line_period: got %0d expected %0d", lt_period, BHT);
        end
    endtask

    task automatic test_frame();
        obs_t e;
        int frames, ft_period, prev_ft_n, vid_cnt, vs_cnt, max_col, max_row;
        logic prev_vs;
        bit en;
        frames = 0; ft_period = -1; prev_ft_n = -1; vid_cnt = 0; vs_cnt = 0; max_col = 0; max_row = 0;
        do_reset(2);
        prev_vs = got_s.vs;
        for (int cyc = 0; cyc < 12000 && frames < 3; cyc++) begin
            en = HAS_EN ? ($urandom_range(0, 2) != 0) : 1'b1;
            tick(en);
            e = exp_s();
            checks++;
            if (got_s !== e) begin
                errors++;
                $display("FAIL frame_scan @%0t: got %s expected %s", $time, fmt(got_s), fmt(e));
            end
            if (got_s.vs !== prev_vs) begin
                checks++;
                if (got_s.col !== 12'd0) begin
                    errors++;
                    $display("FAIL vsync_line_aligned: got col %0d expected 0", got_s.col);
                end
            end
            prev_vs = got_s.vs;
            if (int'(got_s.col) > max_col) max_col = int'(got_s.col);
            if (int'(got_s.row) > max_row) max_row = int'(got_s.row);
            if (last_adv) begin
                if (got_s.ft) begin
                    if (prev_ft_n >= 0 && ft_period < 0) ft_period = int'(ns) - prev_ft_n;
                    prev_ft_n = int'(ns);
                    frames++;
                end
                if (frames == 1) begin
                    if (got_s.vid) vid_cnt++;
                    if (got_s.vs) vs_cnt++;
                end
            end
        end
        checks++;
        if (frames < 3) begin
            errors++;
            $display("FAIL frame_timeout: got %0d frames expected 3", frames);
        end
        checks++;
        if (ft_period != SFRAME) begin
            errors++;
            $display("FAIL frame_period: got %0d expected %0d", ft_period, SFRAME);
        end
        checks++;
        if (vid_cnt != SHA * SVA) begin
            errors++;
            $display("FAIL video_on_count: got %0d expected %0d", vid_cnt, SHA * SVA);
        end
        checks++;
        if (vs_cnt != SVS * SHT) begin
            errors++;
            $display("FAIL vsync_width: got %0d expected %0d", vs_cnt, SVS * SHT);
        end
        checks++;
        if (max_col != SHT - 1 || max_row != SVT - 1) begin
            errors++;
            $display("FAIL scan_bounds: got col %0d row %0d expected col %0d row %0d",
                     max_col, max_row, SHT - 1, SVT - 1);
        end
    endtask

    task automatic test_wrap();
        obs_t want;
        bit found;
        want = {12'd0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        found = 1'b0;
        for (int cyc = 0; cyc < 2 * SFRAME && !found; cyc++) begin
            tick(1'b1);
            if (int'(got_s.col) == SHT - 1 && int'(got_s.row) == SVT - 1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wrap_timeout: got no corner expected col %0d row %0d", SHT - 1, SVT - 1);
        end else begin
            tick(1'b1);
            checks++;
            if (got_s !== want) begin
                errors++;
                $display("FAIL wrap_origin: got %s expected %s", fmt(got_s), fmt(want));
            end
        end
    endtask

    task automatic test_mid_reset();
        obs_t rst_b, rst_s, first_s, e;
        rst_b   = {12'd0, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        rst_s   = {12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        first_s = {12'd0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        repeat ($urandom_range(50, 400)) begin
            tick(1'b1);
            e = exp_s();
            checks++;
            if (got_s !== e) begin
                errors++;
                $display("FAIL pre_reset_scan @%0t: got %s expected %s", $time, fmt(got_s), fmt(e));
            end
        end
        #2;
        reset = 1'b0;
        nb = 0; ns = 0; last_adv = 1'b0;
        #1;
        checks++;
        if (got_b !== rst_b) begin
            errors++;
            $display("FAIL async_reset_big: got %s expected %s", fmt(got_b), fmt(rst_b));
        end
        checks++;
        if (got_s !== rst_s) begin
            errors++;
            $display("FAIL async_reset_small: got %s expected %s", fmt(got_s), fmt(rst_s));
        end
        tick(1'b1);
        tick(1'b1);
        checks++;
        if (got_s !== rst_s) begin
            errors++;
            $display("FAIL reset_held_small: got %s expected %s", fmt(got_s), fmt(rst_s));
        end
        reset = 1'b1;
        tick(1'b1);
        checks++;
        if (got_s !== first_s) begin
            errors++;
            $display("FAIL restart_origin: got %s expected %s", fmt(got_s), fmt(first_s));
        end
    endtask

    task automatic test_stall();
`ifdef DTG_PIX_EN_EN
        obs_t e;
        int lt_period, last_lt, run;
        lt_period = -1; last_lt = -1; run = 0;
        do_reset(1);
        for (int k = 0; k < 3 * 4 * BHT + 8; k++) begin
            tick(k % 4 == 0);
            e = exp_b();
            checks++;
            if (got_b !== e) begin
                errors++;
                $display("FAIL stall_scan @%0t: got %s expected %s", $time, fmt(got_b), fmt(e));
            end
            if (got_b.lt) begin
                run++;
                if (last_lt >= 0 && lt_period < 0) lt_period = k - last_lt;
                last_lt = k;
            end else if (run > 0) begin
                checks++;
                if (run != 1) begin
                    errors++;
                    $display("FAIL stall_tick_width: got %0d expected 1", run);
                end
                run = 0;
            end
        end
        checks++;
        if (lt_period != 4 * BHT) begin
            errors++;
            $display("FAIL stall_line_period: got %0d expected %0d", lt_period, 4 * BHT);
        end
`endif
    endtask

    task automatic test_random();
        obs_t e;
        do_reset(1);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 399) == 0) do_reset(int'($urandom_range(1, 3)));
            tick($urandom_range(0, 1) == 1);
            e = exp_b();
            checks++;
            if (got_b !== e) begin
                errors++;
                $display("FAIL random_big @%0t: got %s expected %s", $time, fmt(got_b), fmt(e));
            end
            e = exp_s();
            checks++;
            if (got_s !== e) begin
                errors++;
                $display("FAIL random_small @%0t: got %s expected %s", $time, fmt(got_s), fmt(e));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pix_en = 1'b1;
        test_reset();
        test_horizontal();
        test_frame();
        test_wrap();
        test_mid_reset();
        test_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_timing_gen.md
# display_timing_gen

Display timing generator for the 1024x768@60 Hz VGA path. It produces the `pixel_row` / `pixel_column` scan coordinates plus `horiz_sync`, `vert_sync` and `video_on`, and drives the sprite/icon overlay, colorizer and world-map readers. Two free-running counters, horizontal and vertical, advance once per pixel. All outputs are registered from those counters, so every downstream consumer sees the same coordinate on the same `clk` edge.

## Interface
Parameters:
- `H_ACTIVE`, 1024, visible pixels per line
- `H_FP`, 24, horizontal front porch (pixels)
- `H_SYNC`, 136, horizontal sync width (pixels)
- `H_BP`, 160, horizontal back porch (pixels)
- `V_ACTIVE`, 768, visible lines per frame
- `V_FP`, 3, vertical front porch (lines)
- `V_SYNC`, 6, vertical sync width (lines)
- `V_BP`, 29, vertical back porch (lines)
- `SYNC_POL`, 1'b0, asserted level of both sync outputs (0 = negative sync)

Ports:
- `clk`  in  1  pixel clock, 65 MHz nominal
- `reset`  in  1  asynchronous, active-low reset
- `pix_en`  in  1  pixel advance enable; present only with `DTG_PIX_EN_EN`
- `pixel_column`  out  12  registered horizontal count, 0..H_TOTAL-1
- `pixel_row`  out  12  registered vertical count, 0..V_TOTAL-1
- `video_on`  out  1  high when the coordinate lies in the visible region
- `horiz_sync`  out  1  horizontal sync at `SYNC_POL` level
- `vert_sync`  out  1  vertical sync at `SYNC_POL` level
- `line_tick`  out  1  one-`clk` pulse with `pixel_column` == 0
- `frame_tick`  out  1  one-`clk` pulse with `pixel_column` == 0 and `pixel_row` == 0

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1344; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 806. Both totals must be ≤ 4096; sums are computed at 13 bits, so no overflow.
- Horizontal counter `h_cnt`: counts 0..H_TOTAL-1 and wraps to 0 on every advance.
- Vertical counter `v_cnt`:
  - Increments only on an advance where `h_cnt` == H_TOTAL-1.
  - Wraps to 0 when it advances from V_TOTAL-1.
  - Simultaneous wrap of both counters takes the scan to (0,0).
- Output decode is a pure function of the current (`h_cnt`, `v_cnt`), registered on the same advance:
  - `video_on` = (h < H_ACTIVE) && (v < V_ACTIVE).
  - `horiz_sync` = SYNC_POL when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL.
  - `vert_sync` = SYNC_POL when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, else ~SYNC_POL. It switches on line boundaries only.
  - `pixel_column` / `pixel_row` carry the raw counts, including blanking values ≥ H_ACTIVE / V_ACTIVE. Consumers gate with `video_on`.
- Reset (asserted low, asynchronous):
  - `h_cnt` and `v_cnt` go to 0.
  - `pixel_column` and `pixel_row` go to 0.
  - `video_on`, `line_tick` and `frame_tick` go to 0.
  - Both syncs go to ~SYNC_POL.
- Reset asserted mid-frame: all of the above take effect immediately, regardless of `clk`. The scan restarts from (0,0); no partial line is completed.

## Timing
- Advance condition: every `clk` edge, or only edges with `pix_en` = 1 when the macro is defined.
- Latency: one advance from counter state to outputs.
- Output sequence after reset release:
  - First advance edge: outputs show (0,0), `video_on` = 1, `line_tick` = `frame_tick` = 1.
  - Counter then moves to (1,0).
- Line period: H_TOTAL advances between `line_tick` pulses.
- Frame period: H_TOTAL*V_TOTAL = 1,083,264 advances between `frame_tick` pulses.
- Ticks: high for exactly one `clk` cycle, and cleared on the next `clk` edge even if no advance occurs.
- Hold on stall: the coordinate, `video_on` and sync outputs hold between advances.

## Configuration
- `DTG_PIX_EN_EN` defined:
  - The `pix_en` port exists; counters and outputs advance only when `pix_en` = 1.
  - Used when `clk` is a faster system clock divided externally.
  - `pix_en` sampled low: all state holds; ticks drop after one cycle.
- Not defined:
  - No `pix_en` port; the block advances every `clk` edge.

## Test plan
- Reset: hold `reset` = 0 for 5 cycles → `pixel_column` = `pixel_row` = 0, `video_on` = 0, both syncs = 1, both ticks = 0. Release → first edge gives `video_on` = 1, `frame_tick` = 1.
- Horizontal timing:
  - `horiz_sync` goes low at `pixel_column` = 1048 and stays low for exactly 136 cycles.
  - `video_on` falls at column 1024.
  - `line_tick` pulses recur every 1344 cycles.
- Vertical timing:
  - `vert_sync` goes low at `pixel_row` = 771 for exactly 6 lines (8064 cycles).
  - `frame_tick` pulses recur every 1,083,264 cycles.
  - `video_on` counts 786,432 high cycles per frame.
- Wrap: at (1343,805) the next output is (0,0) with `frame_tick` = 1. `pixel_row` never exceeds 805 and `pixel_column` never exceeds 1343.
- Mid-frame reset: assert `reset` at (500,300) → outputs clear asynchronously, before the next edge. After release, the scan restarts at (0,0) with `frame_tick`.
- Stall (`DTG_PIX_EN_EN`): drive `pix_en` high 1 cycle in 4 → line period 5376 `clk` cycles. Each tick is exactly 1 cycle wide, and all other outputs are stable across stalled cycles.
